// File: rtl/demux32_buf_pkg.sv
// Shared definitions for the two-port word demultiplexer.
package demux32_buf_pkg;

    // Default data word width and per-port delivered-word counter width.
    localparam int DEF_WIDTH     = 32;
    localparam int DEF_CNT_WIDTH = 16;

    // Destination encoding carried on in_sel.
    localparam logic SEL_PORT1 = 1'b0;
    localparam logic SEL_PORT2 = 1'b1;

endpackage

// File: rtl/demux32_buf_out_slot.sv
// One output port: single-entry holding slot plus a delivered-word counter.
module out_slot
    import demux32_buf_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [WIDTH-1:0]     load_data_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [WIDTH-1:0]     data_o,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 out_hs;

    assign out_hs = valid_q && ready_i;

    // Next-state: a load wins over a drain, so a same-cycle drain and load
    // keeps the slot full with the new word; the counter wraps naturally.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end else if (out_hs) begin
            valid_d = 1'b0;
        end
        if (out_hs) begin
            count_d = count_q + 1'b1;
        end
    end

    // Slot and counter registers; reset discards any held word and
    // suppresses any handshake on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign count_o = count_q;

endmodule

// File: rtl/demux32_buf.sv
// Routes one input word stream to one of two buffered output ports.
module demux32_buf
    import demux32_buf_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    input  logic                 in_sel,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out1_data,
    output logic                 out1_valid,
    input  logic                 out1_ready,
    output logic [WIDTH-1:0]     out2_data,
    output logic                 out2_valid,
    input  logic                 out2_ready,
    output logic [CNT_WIDTH-1:0] out1_count,
    output logic [CNT_WIDTH-1:0] out2_count
);

    logic accept;
    logic load1, load2;

    // Ready reflects only the selected slot: it can take a word if it is
    // empty or is being drained this cycle. Never dependent on in_valid.
    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            if (in_sel == SEL_PORT2) in_ready = !out2_valid || out2_ready;
            else                     in_ready = !out1_valid || out1_ready;
        end
    end

    // Load-enable decode: only the selected slot sees the accepted word.
    always_comb begin
        accept = in_valid && in_ready;
        load1  = accept && (in_sel == SEL_PORT1);
        load2  = accept && (in_sel == SEL_PORT2);
    end

    out_slot #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_slot1 (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load1),
        .load_data_i (in_data),
        .ready_i     (out1_ready),
        .valid_o     (out1_valid),
        .data_o      (out1_data),
        .count_o     (out1_count)
    );

    out_slot #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_slot2 (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load2),
        .load_data_i (in_data),
        .ready_i     (out2_ready),
        .valid_o     (out2_valid),
        .data_o      (out2_data),
        .count_o     (out2_count)
    );

endmodule
